// File: rtl/wordcount_read_stream_source_if.sv
// Command and stream bundle between a read-command controller and the
// wordcount read stream source. The source drives the stream and status.
interface wordcount_read_stream_source_if;
  logic         ctrl_start;
  logic [63:0]  ctrl_addr_offset;
  logic [63:0]  ctrl_xfer_size_in_bytes;
  logic         ctrl_done;
  logic         busy;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tlast;

  modport master (
    input  ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, m_axis_tready,
    output ctrl_done, busy, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, m_axis_tready,
    input  ctrl_done, busy, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/wordcount_read_stream_source.sv
// Deterministic read-stream responder: accepts (start, offset, size) and
// emits ceil(size/64) 512-bit beats whose 32-bit lanes are the lane byte
// address XOR SEED, then pulses ctrl_done. All outputs are registered.
module wordcount_read_stream_source #(
  parameter logic [31:0] SEED = 32'h0000_0000
) (
  input  logic                                clk,
  input  logic                                reset,
  wordcount_read_stream_source_if.master      bus
);

  // LOAD is the one-cycle gap between command capture and beat 0 / done.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [58:0]   beats_q, beats_d;
  logic [58:0]   idx_q, idx_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [511:0]  tdata_q, tdata_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [64:0]   size_round;
  logic [58:0]   idx_inc;
  logic [58:0]   last_idx;
  logic          unused_bits;

  // Only the low 26 index bits reach the 32-bit lane address (idx*64).
  function automatic logic [511:0] gen_beat(input logic [31:0] addr,
                                            input logic [25:0] idx);
    logic [511:0] beat;
    logic [31:0]  base;
    base = addr + {idx, 6'b0};
    for (int i = 0; i < 16; i++) begin
      beat[32*i +: 32] = (base + 32'(4 * i)) ^ SEED;
    end
    return beat;
  endfunction

  // 65-bit rounding sum so a size near 2^64 cannot overflow the beat count.
  assign size_round  = {1'b0, bus.ctrl_xfer_size_in_bytes} + 65'd63;
  assign idx_inc     = idx_q + 59'd1;
  assign last_idx    = beats_q - 59'd1;
  // Upper address bits never reach a lane; rounding remainder is discarded.
  assign unused_bits = ^{bus.ctrl_addr_offset[63:32], size_round[5:0]};

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    // NOTE: every _d gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    done_d   = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ctrl_start) begin
          addr_d  = bus.ctrl_addr_offset[31:0];
          beats_d = size_round[64:6];
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beats_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tvalid_d = 1'b1;
          tdata_d  = gen_beat(addr_q, 26'd0);
          tlast_d  = (beats_q == 59'd1);
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (tvalid_q && bus.m_axis_tready) begin
          if (idx_q == last_idx) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_inc;
            tdata_d = gen_beat(addr_q, idx_inc[25:0]);
            tlast_d = (idx_inc == last_idx);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.ctrl_done     = done_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_wordcount_read_stream_source.sv
// Directed bench for wordcount_read_stream_source: a SEED=0 instance and a
// SEED=all-ones instance share the same command and ready stimulus.
module tb_wordcount_read_stream_source;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wordcount_read_stream_source_if bus ();
  wordcount_read_stream_source_if bus_inv ();

  assign bus_inv.ctrl_start              = bus.ctrl_start;
  assign bus_inv.ctrl_addr_offset        = bus.ctrl_addr_offset;
  assign bus_inv.ctrl_xfer_size_in_bytes = bus.ctrl_xfer_size_in_bytes;
  assign bus_inv.m_axis_tready           = bus.m_axis_tready;

  wordcount_read_stream_source #(.SEED(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wordcount_read_stream_source #(.SEED(32'hFFFF_FFFF)) dut_inv (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_inv)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  int d0, h0;

  // Count completion pulses and handshakes seen at each rising edge.
  always @(posedge clk) begin
    if (bus.ctrl_done) done_cnt <= done_cnt + 1;
    if (bus.m_axis_tvalid && bus.m_axis_tready) hs_cnt <= hs_cnt + 1;
  end

  function automatic logic [511:0] exp_beat(input logic [31:0] addr,
                                            input int unsigned idx,
                                            input logic [31:0] seed);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = (addr + 32'(idx * 64) + 32'(4 * i)) ^ seed;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tvalid"}, 512'(bus.m_axis_tvalid), 512'd0);
    check({tag, "_tlast"},  512'(bus.m_axis_tlast),  512'd0);
    check({tag, "_tdata"},  bus.m_axis_tdata,        512'd0);
    check({tag, "_done"},   512'(bus.ctrl_done),     512'd0);
    check({tag, "_busy"},   512'(bus.busy),          512'd0);
  endtask

  // Issue a command; returns just after the edge where beat 0 (or done) appears.
  task automatic start_cmd(input logic [63:0] addr, input logic [63:0] size);
    bus.ctrl_start              = 1'b1;
    bus.ctrl_addr_offset        = addr;
    bus.ctrl_xfer_size_in_bytes = size;
    tick();
    bus.ctrl_start = 1'b0;
    check("start_busy",   512'(bus.busy),          512'd1);
    check("start_tvalid", 512'(bus.m_axis_tvalid), 512'd0);
    check("start_done",   512'(bus.ctrl_done),     512'd0);
    tick();
  endtask

  // Walk the stream beat by beat; ready follows pat, optional stray start at cycle 2.
  task automatic run_stream(input logic [31:0] addr, input int unsigned nbeats,
                            input logic [7:0] pat, input bit inject);
    int unsigned idx = 0;
    int cyc = 0;
    while (idx < nbeats && cyc < 100) begin
      check("beat_tvalid", 512'(bus.m_axis_tvalid), 512'd1);
      check("beat_busy",   512'(bus.busy),          512'd1);
      check("beat_tdata",  bus.m_axis_tdata,        exp_beat(addr, idx, 32'h0));
      check("beat_tlast",  512'(bus.m_axis_tlast),  512'(idx == nbeats - 1));
      check("seed_tdata",  bus_inv.m_axis_tdata,    exp_beat(addr, idx, 32'hFFFF_FFFF));
      bus.m_axis_tready = pat[cyc % 8];
      if (inject && cyc == 2) begin
        bus.ctrl_start              = 1'b1;
        bus.ctrl_addr_offset        = 64'hDEAD_0000;
        bus.ctrl_xfer_size_in_bytes = 64'd64;
      end else begin
        bus.ctrl_start = 1'b0;
      end
      tick();
      if (pat[cyc % 8]) idx++;
      cyc++;
    end
    bus.ctrl_start = 1'b0;
    check("beat_count",  512'(idx),                 512'(nbeats));
    check("end_done",    512'(bus.ctrl_done),       512'd1);
    check("end_tvalid",  512'(bus.m_axis_tvalid),   512'd0);
    check("end_tlast",   512'(bus.m_axis_tlast),    512'd0);
    tick();
    check("post_done",   512'(bus.ctrl_done),       512'd0);
    check("post_busy",   512'(bus.busy),            512'd0);
  endtask

  initial begin
    // Reset sweep with start and ready asserted throughout.
    reset = 1'b0;
    bus.ctrl_start              = 1'b1;
    bus.ctrl_addr_offset        = 64'h4000;
    bus.ctrl_xfer_size_in_bytes = 64'd640;
    bus.m_axis_tready           = 1'b1;
    repeat (10) begin
      tick();
      check_quiet("reset");
    end
    check("reset_hs",   512'(hs_cnt),   512'd0);
    check("reset_done", 512'(done_cnt), 512'd0);
    reset = 1'b1;
    bus.ctrl_start = 1'b0;
    tick();
    check_quiet("idle");

    // Basic two-beat command with hand-computed lanes.
    d0 = done_cnt;
    start_cmd(64'h8000_0000, 64'd128);
    check("basic_lane0",     512'(bus.m_axis_tdata[31:0]),     512'h8000_0000);
    check("basic_lane15",    512'(bus.m_axis_tdata[511:480]),  512'h8000_003C);
    check("seed_lane0",      512'(bus_inv.m_axis_tdata[31:0]), 512'h7FFF_FFFF);
    run_stream(32'h8000_0000, 2, 8'hFF, 1'b0);
    check("basic_done_cnt",  512'(done_cnt - d0), 512'd1);

    // Backpressure: four beats under an irregular ready pattern.
    d0 = done_cnt;
    h0 = hs_cnt;
    start_cmd(64'h1234_5670, 64'd256);
    run_stream(32'h1234_5670, 4, 8'b1011_0010, 1'b0);
    check("bp_hs",       512'(hs_cnt - h0),   512'd4);
    check("bp_done_cnt", 512'(done_cnt - d0), 512'd1);
    bus.m_axis_tready = 1'b1;

    // Zero-size command: done one cycle after the start edge, no beats.
    h0 = hs_cnt;
    bus.ctrl_start              = 1'b1;
    bus.ctrl_addr_offset        = 64'h3000;
    bus.ctrl_xfer_size_in_bytes = 64'd0;
    tick();
    bus.ctrl_start = 1'b0;
    check("zero_busy",   512'(bus.busy),          512'd1);
    check("zero_done0",  512'(bus.ctrl_done),     512'd0);
    tick();
    check("zero_done1",  512'(bus.ctrl_done),     512'd1);
    check("zero_tvalid", 512'(bus.m_axis_tvalid), 512'd0);
    tick();
    check("zero_done2",  512'(bus.ctrl_done),     512'd0);
    check("zero_busy2",  512'(bus.busy),          512'd0);
    check("zero_hs",     512'(hs_cnt - h0),       512'd0);

    // Size rounding boundaries.
    start_cmd(64'h100, 64'd1);
    run_stream(32'h100, 1, 8'hFF, 1'b0);
    start_cmd(64'h2000, 64'd100);
    run_stream(32'h2000, 2, 8'hFF, 1'b0);

    // 32-bit address wrap; upper offset bits do not reach the lanes.
    start_cmd(64'h0000_0001_FFFF_FFC0, 64'd128);
    check("wrap_lane0", 512'(bus.m_axis_tdata[31:0]), 512'hFFFF_FFC0);
    run_stream(32'hFFFF_FFC0, 2, 8'hFF, 1'b0);

    // Stray start during a stream is ignored and not queued.
    start_cmd(64'h5000, 64'd512);
    run_stream(32'h5000, 8, 8'hFF, 1'b1);
    tick();
    check("noqueue_busy",   512'(bus.busy),          512'd0);
    check("noqueue_tvalid", 512'(bus.m_axis_tvalid), 512'd0);

    // Abort after two of eight beats.
    d0 = done_cnt;
    h0 = hs_cnt;
    start_cmd(64'h9000, 64'd512);
    tick();
    tick();
    check("abort_hs_before", 512'(hs_cnt - h0), 512'd2);
    reset = 1'b0;
    #1;
    check_quiet("abort");
    repeat (3) tick();
    check("abort_hs_after", 512'(hs_cnt - h0),   512'd2);
    check("abort_no_done",  512'(done_cnt - d0), 512'd0);
    reset = 1'b1;
    tick();
    check_quiet("after_abort");

    // Fresh command after the abort completes normally.
    d0 = done_cnt;
    start_cmd(64'hA000, 64'd64);
    run_stream(32'hA000, 1, 8'hFF, 1'b0);
    check("recover_done_cnt", 512'(done_cnt - d0), 512'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wordcount_read_stream_source.md
# wordcount_read_stream_source

Synthesizable responder for the `reader_ctrl_*` / `reader_s_axis_*` interface consumed by `wordcout_top`. It accepts a read command (start, byte offset, byte count) and emits a deterministic, address-derived stream of 512-bit beats with valid/ready/last handshaking. On completion it pulses done. It replaces the tied-off constant stream in the wordcount simulation and serves as a stand-in read master for hardware bring-up without global memory.

## Interface
- `SEED`, default `32'h0000_0000`: XOR mask applied to every generated 32-bit lane.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion (0) immediately forces every register to its reset value. Deassertion is synchronous to `clk`.
- `ctrl_start`  in  1  command strobe; sampled only in IDLE.
- `ctrl_addr_offset`  in  64  byte address of the first beat; captured with `ctrl_start`.
- `ctrl_xfer_size_in_bytes`  in  64  transfer length in bytes; captured with `ctrl_start`.
- `ctrl_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after an accepted start through the `ctrl_done` cycle, inclusive.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tdata`  out  512  beat data.
- `m_axis_tlast`  out  1  final beat of the command.

## Operation
- States:
  - IDLE: outputs quiet.
  - STREAM: beats presented.
  - DONE: `ctrl_done`=1 for exactly one cycle, then IDLE.
- IDLE with `ctrl_start`=1:
  - Capture `addr = ctrl_addr_offset`.
  - Compute `beats = ceil(size/64)` as `(size + 63) >> 6`, using 65-bit intermediate arithmetic so no overflow.
  - Clear the beat index `idx`.
  - If `beats`=0, go to DONE. Otherwise go to STREAM.
- `ctrl_start` outside IDLE is ignored. There is no queueing.
- Beat data:
  - For beat `idx` and lane `i` (0..15): `lane = (addr[31:0] + idx*64 + 4*i) mod 2^32 ^ SEED`.
  - Lane `i` occupies `tdata[32*i+31 : 32*i]`.
  - Address arithmetic wraps modulo 2^32; there is no error on wrap.
- Partial final beat (size not a multiple of 64): full beat emitted. No byte masking; the sink uses the size it requested.
- STREAM handshake: on `tvalid && tready`, increment `idx`.
  - If this was the last beat (`idx == beats-1`), go to DONE.
  - Otherwise the next beat is presented in the following cycle.
- `tlast` = 1 exactly when `idx == beats-1` while `tvalid`=1.
- Reset mid-operation:
  - All state is discarded immediately.
  - No `ctrl_done` is generated for the aborted command.
  - After deassertion the block is in IDLE.

## Timing
- Reset values (all outputs): `ctrl_done`=0, `busy`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0. State = IDLE.
- Outputs are registered. There is no combinational path from `m_axis_tready` to any output.
- Start latency: start sampled at edge N → `tvalid`=1 with beat 0 after edge N+1.
- Throughput: one beat per cycle while `tready`=1 (sustained 100%).
- AXI-stream rules:
  - Once `tvalid`=1, `tvalid`, `tdata` and `tlast` are held stable until the handshake.
  - `tvalid` never depends on `tready`.
- Last handshake at edge M:
  - After edge M: `tvalid`=0, `ctrl_done`=1.
  - After edge M+1: `ctrl_done`=0, `busy`=0.
  - A start may be accepted at edge M+2.
- Zero-size command (start at edge N): `ctrl_done`=1 after edge N+1; no beat is emitted.
- `busy` goes high after the start edge, so a controller polling `busy`=0 must allow one cycle after its start.

## Test plan
- Reset sweep: hold `reset`=0 for 10 cycles, with `ctrl_start`=1 and `tready`=1 during reset → all outputs 0; no beats; no done.
- Basic command: addr `0x80000000`, size 128, `tready`=1, `SEED`=0 →
  - Beat 0: lane0=`0x80000000`, lane15=`0x8000003C`, `tlast`=0.
  - Beat 1: lane0=`0x80000040`, `tlast`=1.
  - Consecutive cycles; `ctrl_done` one cycle after beat 1.
- Backpressure: size 256; toggle `tready` pseudo-randomly →
  - Exactly 4 handshakes with lanes per the formula.
  - `tdata`/`tlast` stable whenever `tvalid`=1 and `tready`=0.
  - Single `ctrl_done`.
- Boundaries:
  - Size 0 → no beats, done at N+1.
  - Size 1 and size 100 → 1 and 2 beats, `tlast` on the final beat.
  - addr `0xFFFFFFC0`, size 128 → beat 1 lane0=`0x00000000` (wrap).
  - `SEED`=`0xFFFFFFFF` → beat-0 lane0 inverted.
- Ignored start and abort:
  - Pulse `ctrl_start` with a different addr during STREAM → the stream is unaffected.
  - Assert `reset` after 2 of 8 beats → outputs 0 within the same cycle; no done.
  - A new command after release completes normally.
